regfile_write_queue: RTL
========================

# regfile_write_queue

Write-back queue that sits directly upstream of the 32x32 register file's single write port. Accepts write requests through a valid/ready handshake, buffers up to DEPTH of them, and drains one per cycle into WriteRegister/WriteData/RegWrite when WriteEnable is high. It also sits on both read paths and forwards the newest pending value for a read address, so reads never see stale data while writes are queued.

## Interface
- DEPTH, 4: queue entries; power of two, minimum 2.
- DATA_WIDTH, 32: register data width.
- ADDR_WIDTH, 5: register address width.
- Clk  in  1  clock; all state updates on the positive edge.
- Reset  in  1  asynchronous, active-high; clears all queue state immediately.
- InValid  in  1  a write request is present.
- InReady  out  1  queue can accept a request.
- InRegister  in  ADDR_WIDTH  destination register of the request.
- InData  in  DATA_WIDTH  data of the request.
- WriteEnable  in  1  drain permission; when low, the head is held.
- WriteRegister  out  ADDR_WIDTH  to regfile; head address, 0 when empty.
- WriteData  out  DATA_WIDTH  to regfile; head data, 0 when empty.
- RegWrite  out  1  to regfile; high when the queue is non-empty and WriteEnable is high.
- ReadRegister1, ReadRegister2  in  ADDR_WIDTH  read addresses, shared with the regfile.
- RfReadData1, RfReadData2  in  DATA_WIDTH  raw regfile read data.
- ReadData1, ReadData2  out  DATA_WIDTH  forwarded read data.
- Count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Circular buffer with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- InReady = (Count < DEPTH). It depends only on state and gives no credit for a same-cycle dequeue.
- Enqueue occurs when InValid and InReady are both high at a rising edge.
- InRegister == 0: the request is accepted and discarded. It is never stored and Count is unchanged.
- Dequeue occurs when Count > 0 and WriteEnable is high at a rising edge. The regfile captures the head on that same edge.
- Simultaneous enqueue and dequeue leaves Count unchanged and advances both pointers.
- When full, an enqueue and a dequeue cannot happen in the same cycle because InReady is low.
- Forwarding for port k (k = 1, 2):
  - If ReadRegisterk == 0, ReadDatak = 0.
  - Otherwise, if any occupied entry matches ReadRegisterk, ReadDatak = data of the newest (closest to tail) matching entry. The head entry is included.
  - Otherwise, ReadDatak = RfReadDatak.
- A request being enqueued in the current cycle is not forwarded until the next cycle.
- Forwarding is purely combinational on state and read inputs; there is no extra latency.

## Timing
- Reset values: Count=0, InReady=1, RegWrite=0, WriteRegister=0, WriteData=0. ReadData1/2 pass RfReadData1/2 through, with register 0 forced to 0.
- Reset asserted mid-operation discards all pending entries immediately. Lost writes are acceptable; the upstream block reissues them.
- Empty-queue latency: a request accepted at edge N drives RegWrite during cycle N..N+1 and lands in the regfile at edge N+1.
- Throughput: one write per cycle sustained while WriteEnable is high.
- When WriteEnable is low, RegWrite=0 and WriteRegister/WriteData continue to show the held head.
- Queue states:
  - EMPTY (Count=0): InReady=1, RegWrite=0.
  - PARTIAL (0<Count<DEPTH): InReady=1.
  - FULL (Count=DEPTH): InReady=0.
- State transitions follow only from the enqueue and dequeue rules above.

## Structure
- Shared package regfile_pkg holds REG_ADDR_WIDTH=5, REG_DATA_WIDTH=32, ZERO_REG=5'd0 and NUM_REGS=32. The regfile and its benches use the same package.
- Sub-module regfile_bypass_lookup:
  - Inputs: entry array, occupancy mask, head pointer and one read address.
  - Outputs: hit flag and newest matching data.
  - Instantiated twice, once per read port.
- Queue storage and pointers live in the top module.

## Test plan
- Reset, then enqueue (2, 42) with WriteEnable=1 -> RegWrite=1, WriteRegister=2, WriteData=42 the next cycle. The regfile then reads 42 on both ports.
- WriteEnable=0, enqueue (5,1), (6,2), (5,3), (7,4) -> Count=4 and InReady=0. A fifth request is stalled with no state change. ReadRegister1=5 gives ReadData1=3, not 1.
- With the queue from the previous scenario, raise WriteEnable -> the regfile receives 5,6,5,7 in order on four consecutive edges, ending with Count=0 and reg5=3.
- With Count=2 and WriteEnable=1, hold InValid=1 for 6 cycles -> Count stays 2 and writes drain in order with no loss or duplication.
- Enqueue (0, 15) -> Count unchanged, RegWrite stays 0, ReadData1 for register 0 = 0.
- Assert Reset with Count=3 -> Count=0, InReady=1 and RegWrite=0 immediately. A previously pending register reads its old regfile value.

Source files
------------

// File: rtl/regfile_write_queue_pkg.sv
// Shared register-file constants used by the regfile, its write queue and their benches.
package regfile_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS       = 32;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Write-request handshake, regfile write port and both read paths of the write queue.
// master: upstream/regfile side; slave: the queue itself.
interface regfile_write_queue_if
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // write request handshake
  logic                  InValid;
  logic                  InReady;
  logic [ADDR_WIDTH-1:0] InRegister;
  logic [DATA_WIDTH-1:0] InData;

  // regfile write port
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;

  // read paths
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [DATA_WIDTH-1:0] RfReadData1;
  logic [DATA_WIDTH-1:0] RfReadData2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  logic [CNT_W-1:0]      Count;

  modport master (
    output InValid, InRegister, InData, WriteEnable,
    output ReadRegister1, ReadRegister2, RfReadData1, RfReadData2,
    input  InReady, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2, Count
  );

  modport slave (
    input  InValid, InRegister, InData, WriteEnable,
    input  ReadRegister1, ReadRegister2, RfReadData1, RfReadData2,
    output InReady, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2, Count
  );

endinterface

// File: rtl/regfile_write_queue_bypass_lookup.sv
// regfile_bypass_lookup: finds the newest occupied queue entry matching one read address.
// Ports: entry_addr/entry_data (storage), occupied (mask by slot), head (oldest slot),
//        rd_addr (lookup key); hit_c / hit_data_c (combinational result).
module regfile_bypass_lookup #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data,
  input  logic [DEPTH-1:0]                 occupied,
  input  logic [$clog2(DEPTH)-1:0]         head,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             hit_c,
  output logic [DATA_WIDTH-1:0]            hit_data_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk slots oldest-to-newest from head; the last match seen is the newest one.
  always_comb begin
    hit_c      = 1'b0;
    hit_data_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (occupied[idx] && (entry_addr[idx] == rd_addr)) begin
        hit_c      = 1'b1;
        hit_data_c = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: circular write-back buffer in front of the regfile write port,
// with read forwarding of the newest pending value on both read ports.
// Ports: Clk, Reset (async, active-high), bus (slave side of regfile_write_queue_if).
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input logic                  Clk,
  input logic                  Reset,
  regfile_write_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [PTR_W-1:0]                 head_q;
  logic [PTR_W-1:0]                 tail_q;
  logic [CNT_W-1:0]                 count_q;

  logic                  empty_c;
  logic                  full_c;
  logic                  enq_c;
  logic                  deq_c;
  logic [DEPTH-1:0]      occupied_c;
  logic                  hit1_c;
  logic                  hit2_c;
  logic [DATA_WIDTH-1:0] fwd1_c;
  logic [DATA_WIDTH-1:0] fwd2_c;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));

  // Writes to register 0 are handshaken but never stored.
  assign enq_c = bus.InValid && !full_c && (bus.InRegister != ADDR_WIDTH'(ZERO_REG));
  assign deq_c = !empty_c && bus.WriteEnable;

  // Queue storage and pointers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_c) begin
        addr_q[tail_q] <= bus.InRegister;
        data_q[tail_q] <= bus.InData;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (deq_c) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (enq_c && !deq_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!enq_c && deq_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // A slot is occupied when its distance from head is below the count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_occ
    assign occupied_c[j] = CNT_W'(PTR_W'(PTR_W'(j) - head_q)) < count_q;
  end

  regfile_bypass_lookup #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lookup1 (
    .entry_addr(addr_q), .entry_data(data_q), .occupied(occupied_c), .head(head_q),
    .rd_addr(bus.ReadRegister1), .hit_c(hit1_c), .hit_data_c(fwd1_c)
  );

  regfile_bypass_lookup #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lookup2 (
    .entry_addr(addr_q), .entry_data(data_q), .occupied(occupied_c), .head(head_q),
    .rd_addr(bus.ReadRegister2), .hit_c(hit2_c), .hit_data_c(fwd2_c)
  );

  // Regfile write port shows the head even while held; zero when empty.
  assign bus.InReady       = !full_c;
  assign bus.RegWrite      = deq_c;
  assign bus.WriteRegister = empty_c ? '0 : addr_q[head_q];
  assign bus.WriteData     = empty_c ? '0 : data_q[head_q];
  assign bus.Count         = count_q;

  assign bus.ReadData1 = (bus.ReadRegister1 == ADDR_WIDTH'(ZERO_REG)) ? '0 :
                         (hit1_c ? fwd1_c : bus.RfReadData1);
  assign bus.ReadData2 = (bus.ReadRegister2 == ADDR_WIDTH'(ZERO_REG)) ? '0 :
                         (hit2_c ? fwd2_c : bus.RfReadData2);

endmodule
